usrt_ctrl: RTL
==============

Name: usrt_ctrl

Overview:
APB-slave controller that sequences the USRT datapath. It owns the baud tick, the TX frame sequencer and the RX frame checker, and exposes DATA/STATUS/BAUD registers to the AMBA side. It replaces ad-hoc enable decoding with explicit FSMs and a pready back-pressure handshake. Frame format: start=1, 8 data bits LSB first, even parity (XOR of data), stop=0; idle line=0.

Parameters:
BAUD_RST, 79, reset value of BAUD register; tick period = BAUD+1 pClk cycles
ADDR_W, 4, width of paddr

Ports:
pClk  in  1  system/APB clock
rst  in  1  synchronous, active-high reset
paddr  in  ADDR_W  register address
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1=write, 0=read
pwdata  in  8  write data
prdata  out  8  read data, valid when psel&penable&pready
pready  out  1  transfer completion
pslverr  out  1  error response, valid with pready
uclk  out  1  one-pClk baud tick pulse to the line partner
tx  out  1  serial out
rx  in  1  serial in, sampled on uclk
irq  out  1  rx_valid | any sticky error

Behaviour:
- Reset (rst=1 at posedge pClk): tx=0, uclk=0, prdata=0, pready=1, pslverr=0, irq=0, both FSMs IDLE, BAUD=BAUD_RST, STATUS=0, baud counter=0. Reset mid-frame aborts the frame immediately; no partial data is kept.
- Registers: 0x0 DATA (W: start TX; R: rx_data, clears rx_valid); 0x1 STATUS (R: b0 tx_busy, b1 rx_valid, b2 parity_err, b3 frame_err, b4 overrun; W: write-1-to-clear b2..b4); 0x2 BAUD (RW, 8 bit). Other addresses: pready=1, pslverr=1, no side effect, prdata=0.
- APB: setup phase is ignored; the access phase (psel&penable) completes when pready=1. pready is combinational and deasserts only for a DATA write while tx_busy=1.
- Baud: 8-bit counter runs 0..BAUD; uclk=1 for one cycle when counter==BAUD, then the counter wraps to 0. A BAUD write sets counter=0 the next cycle. BAUD=0 gives a tick every cycle.
- TX FSM: IDLE -> LOAD -> START -> DATA(bit_cnt 0..7) -> PARITY -> STOP -> IDLE.
  - A DATA write completing in IDLE latches shift reg and parity and enters LOAD; tx_busy=1 from the next cycle.
  - Every following state advances only on uclk. On entry, tx=1 in START, data[bit_cnt] in DATA, parity in PARITY, 0 in STOP and IDLE.
  - tx_busy clears on the uclk that leaves STOP. The frame lasts exactly 11 ticks.
  - A DATA write while busy holds pready=0. It completes in the first cycle the FSM is IDLE and is loaded in that same cycle.
- RX FSM (samples rx only on uclk): IDLE -> DATA when rx=1 is sampled. Then 8 samples into shift reg LSB first, PARITY sample, STOP sample, -> IDLE.
  - Parity mismatch: parity_err=1, frame dropped.
  - Stop sample !=0: frame_err=1, frame dropped. Parity is checked first; when both fail, only parity_err is set.
  - Good frame with rx_valid=0: rx_data updated, rx_valid=1 on the cycle after the stop tick.
  - Good frame with rx_valid=1: overrun=1, old rx_data kept.
- Simultaneous events in one cycle:
  - DATA read and rx_valid set: set wins, and the read returns the old data.
  - STATUS W1C and new error set: set wins.
- irq is registered, so it follows STATUS one cycle later.

Decomposition:
- Package usrt_pkg holds:
  - register addresses: ADDR_DATA=0, ADDR_STATUS=1, ADDR_BAUD=2
  - STATUS bit indices
  - tx_state_t {IDLE, LOAD, START, DATA, PARITY, STOP} and rx_state_t {IDLE, DATA, PARITY, STOP}
  - START_BIT=1, STOP_BIT=0
- Sub-module usrt_baud_tick (pClk, rst, div[7:0], restart -> tick) is natural. The TX and RX FSMs stay in usrt_ctrl.

Test Plan:
- BAUD=3, write DATA=0xA5 -> tx per tick: 1, 1,0,1,0,0,1,0,1, 0, 0. tx_busy high for 44 pClk after LOAD, then STATUS reads 0x00.
- BAUD=3, drive rx frame 1, 0,0,1,1,1,1,0,0, 0, 0 -> STATUS=0x02 and irq=1. Read DATA=0x3C, then STATUS=0x00.
- Same frame with parity bit 1 -> STATUS=0x04 and rx_valid=0. Write STATUS=0x04 -> STATUS=0x00.
- Two good frames 0x3C then 0x11 without reading -> STATUS=0x12, DATA reads 0x3C.
- DATA write 0x55 while tx_busy -> pready=0 until the FSM returns to IDLE. The second frame starts on the next tick, with no idle gap beyond LOAD.
- Assert rst mid-TX at bit 4 -> tx=0 and STATUS=0x00 next cycle. Read of 0x7 -> pslverr=1, prdata=0.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT controller slice:
// register map, STATUS layout, FSM encodings and frame constants.
package usrt_pkg;

    localparam int ADDR_DATA   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_BAUD   = 2;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_PAR_ERR  = 2;
    localparam int ST_FRM_ERR  = 3;
    localparam int ST_OVERRUN  = 4;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Even parity bit: makes the total count of ones in data+parity even.
    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/usrt_ctrl_if.sv
// APB slave bundle for the USRT controller.
// master drives the request side, slave returns data and completion.
interface usrt_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/usrt_baud_tick.sv
// Baud tick generator: counts 0..div and pulses tick at div.
// A restart forces the count back to 0 on the following cycle.
module usrt_baud_tick (
    input  logic       pClk,
    input  logic       rst,
    input  logic [7:0] i_div,
    input  logic       i_restart,
    output logic       o_tick
);

    logic [7:0] r_cnt;
    logic       w_hit;

    assign w_hit  = (r_cnt == i_div);
    assign o_tick = w_hit;

    // Free-running divider counter, wraps after the terminal count
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_restart || w_hit) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/usrt_ctrl.sv
// USRT controller: APB register file, baud tick, TX frame
// sequencer and RX frame checker with sticky error flags.
module usrt_ctrl
    import usrt_pkg::*;
#(
    parameter logic [7:0] BAUD_RST = 8'd79,
    parameter int         ADDR_W   = 4
) (
    input  logic  pClk,
    input  logic  rst,
    usrt_ctrl_if.slave apb,
    output logic  uclk,
    output logic  tx,
    input  logic  rx,
    output logic  irq
);

    logic [7:0] r_baud;
    logic       w_tick;

    tx_state_t  r_tx_state;
    tx_state_t  w_tx_nxt;
    logic [7:0] r_tx_shift;
    logic       r_tx_par;
    logic [2:0] r_tx_cnt;
    logic       w_tx_busy;
    logic       w_tx;

    rx_state_t  r_rx_state;
    rx_state_t  w_rx_nxt;
    logic [7:0] r_rx_shift;
    logic       r_rx_par;
    logic [2:0] r_rx_cnt;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_par_err;
    logic       r_frm_err;
    logic       r_overrun;
    logic       r_irq;

    logic       w_stop_evt;
    logic       w_par_bad;
    logic       w_frm_bad;
    logic       w_set_valid;
    logic       w_set_ovr;
    logic       w_set_perr;
    logic       w_set_ferr;

    logic       w_access;
    logic       w_sel_data;
    logic       w_sel_status;
    logic       w_sel_baud;
    logic       w_sel_bad;
    logic       w_ready;
    logic       w_done;
    logic       w_data_wr;
    logic       w_data_rd;
    logic       w_status_wr;
    logic       w_baud_wr;
    logic [7:0] w_status;
    logic [7:0] w_prdata;

    // APB address decode and completion qualifiers
    assign w_access     = apb.psel & apb.penable;
    assign w_sel_data   = (apb.paddr == ADDR_W'(ADDR_DATA));
    assign w_sel_status = (apb.paddr == ADDR_W'(ADDR_STATUS));
    assign w_sel_baud   = (apb.paddr == ADDR_W'(ADDR_BAUD));
    assign w_sel_bad    = ~(w_sel_data | w_sel_status | w_sel_baud);

    assign w_tx_busy = (r_tx_state != TX_IDLE);

    // Only a DATA write against a busy transmitter is stalled
    assign w_ready = ~(w_access & apb.pwrite & w_sel_data & w_tx_busy);
    assign w_done  = w_access & w_ready;

    assign w_data_wr   = w_done & apb.pwrite & w_sel_data;
    assign w_data_rd   = w_done & ~apb.pwrite & w_sel_data;
    assign w_status_wr = w_done & apb.pwrite & w_sel_status;
    assign w_baud_wr   = w_done & apb.pwrite & w_sel_baud;

    assign w_status = {3'b000, r_overrun, r_frm_err, r_par_err,
                       r_rx_valid, w_tx_busy};

    // Read mux; returns zero outside a read access or for holes
    always_comb begin
        w_prdata = 8'h00;
        if (w_access && !apb.pwrite) begin
            unique case (1'b1)
                w_sel_data:   w_prdata = r_rx_data;
                w_sel_status: w_prdata = w_status;
                w_sel_baud:   w_prdata = r_baud;
                default:      w_prdata = 8'h00;
            endcase
        end
    end

    assign apb.prdata  = w_prdata;
    assign apb.pready  = w_ready;
    assign apb.pslverr = w_access & w_sel_bad;

    // BAUD divisor register
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_baud <= BAUD_RST;
        end else if (w_baud_wr) begin
            r_baud <= apb.pwdata;
        end
    end

    usrt_baud_tick u_baud (
        .pClk      (pClk),
        .rst       (rst),
        .i_div     (r_baud),
        .i_restart (w_baud_wr),
        .o_tick    (w_tick)
    );

    assign uclk = w_tick;

    // TX state register
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_nxt;
        end
    end

    // TX next state: load on a DATA write, then advance per tick
    always_comb begin
        w_tx_nxt = r_tx_state;
        case (r_tx_state)
            TX_IDLE:   if (w_data_wr) w_tx_nxt = TX_LOAD;
            TX_LOAD:   if (w_tick) w_tx_nxt = TX_START;
            TX_START:  if (w_tick) w_tx_nxt = TX_DATA;
            TX_DATA:   if (w_tick && r_tx_cnt == 3'd7) w_tx_nxt = TX_PARITY;
            TX_PARITY: if (w_tick) w_tx_nxt = TX_STOP;
            TX_STOP:   if (w_tick) w_tx_nxt = TX_IDLE;
            default:   w_tx_nxt = TX_IDLE;
        endcase
    end

    // TX line value for the current state
    always_comb begin
        w_tx = STOP_BIT;
        case (r_tx_state)
            TX_START:  w_tx = START_BIT;
            TX_DATA:   w_tx = r_tx_shift[r_tx_cnt];
            TX_PARITY: w_tx = r_tx_par;
            default:   w_tx = STOP_BIT;
        endcase
    end

    assign tx = w_tx;

    // TX datapath: capture byte/parity, step bit index in DATA
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_tx_shift <= 8'h00;
            r_tx_par   <= 1'b0;
            r_tx_cnt   <= 3'd0;
        end else if (w_data_wr) begin
            r_tx_shift <= apb.pwdata;
            r_tx_par   <= even_par(apb.pwdata);
            r_tx_cnt   <= 3'd0;
        end else if (w_tick && r_tx_state == TX_DATA) begin
            r_tx_cnt <= r_tx_cnt + 3'd1;
        end
    end

    // RX state register
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_nxt;
        end
    end

    // RX next state: start bit opens a frame, each tick advances
    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:   if (w_tick && rx == START_BIT) w_rx_nxt = RX_DATA;
            RX_DATA:   if (w_tick && r_rx_cnt == 3'd7) w_rx_nxt = RX_PARITY;
            RX_PARITY: if (w_tick) w_rx_nxt = RX_STOP;
            RX_STOP:   if (w_tick) w_rx_nxt = RX_IDLE;
            default:   w_rx_nxt = RX_IDLE;
        endcase
    end

    // RX frame verdict at the stop sample; parity outranks framing
    always_comb begin
        w_stop_evt  = w_tick & (r_rx_state == RX_STOP);
        w_par_bad   = (r_rx_par != even_par(r_rx_shift));
        w_frm_bad   = (rx != STOP_BIT);
        w_set_perr  = w_stop_evt & w_par_bad;
        w_set_ferr  = w_stop_evt & ~w_par_bad & w_frm_bad;
        w_set_valid = w_stop_evt & ~w_par_bad & ~w_frm_bad & ~r_rx_valid;
        w_set_ovr   = w_stop_evt & ~w_par_bad & ~w_frm_bad & r_rx_valid;
    end

    // RX datapath: shift data LSB first, then capture parity
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_rx_shift <= 8'h00;
            r_rx_par   <= 1'b0;
            r_rx_cnt   <= 3'd0;
        end else if (w_tick) begin
            case (r_rx_state)
                RX_IDLE: r_rx_cnt <= 3'd0;
                RX_DATA: begin
                    r_rx_shift <= {rx, r_rx_shift[7:1]};
                    r_rx_cnt   <= r_rx_cnt + 3'd1;
                end
                RX_PARITY: r_rx_par <= rx;
                default: ;
            endcase
        end
    end

    // Received byte and valid flag; a new frame beats a DATA read
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_set_valid) begin
                r_rx_data <= r_rx_shift;
            end
            if (w_set_valid) begin
                r_rx_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error beats write-one-to-clear
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_set_perr) begin
                r_par_err <= 1'b1;
            end else if (w_status_wr && apb.pwdata[ST_PAR_ERR]) begin
                r_par_err <= 1'b0;
            end
            if (w_set_ferr) begin
                r_frm_err <= 1'b1;
            end else if (w_status_wr && apb.pwdata[ST_FRM_ERR]) begin
                r_frm_err <= 1'b0;
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (w_status_wr && apb.pwdata[ST_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Interrupt follows the STATUS flags one cycle later
    always_ff @(posedge pClk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_rx_valid | r_par_err | r_frm_err | r_overrun;
        end
    end

    assign irq = r_irq;

endmodule
